// File: rtl/alu_csr_regfile.sv
// CSR register file for the APB ALU: operand/CTRL registers, FIFO_IN push, RESULT pop.
// Optional interrupt logic is built when CSR_IRQ_EN is defined.
module alu_csr_regfile #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_SIZE      = 16,
  parameter int NUM_OPERANDS   = 2,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [APB_BUS_SIZE-1:0]   wdata,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [APB_BUS_SIZE-1:0]   rdata,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [NUM_OPERANDS*DATA_SIZE+ID_SIZE+OPERATION_SIZE-1:0] csr_data,
  input  logic                      fifo_in_full,
  input  logic                      fifo_out_empty,
  output logic                      fifo_out_rd,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic                      irq
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_RESULT = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ    = ADDR_WIDTH'(3);
  localparam int HDR = ID_SIZE + OPERATION_SIZE;

  typedef enum logic {IDLE, PUSH} state_t;

  state_t                      state_q;
  logic                        start_q;
  logic [OPERATION_SIZE-1:0]   op_q;
  logic [ID_SIZE-1:0]          id_q;
  logic                        auto_id_q;
  logic [CNT_WIDTH-1:0]        cmd_count_q;
  logic [CNT_WIDTH-1:0]        res_count_q;
  logic [DATA_SIZE-1:0]        data_q [NUM_OPERANDS];
  logic [FIFO_OUT_WIDTH-1:0]   result_q;
  logic                        result_valid_q;
  logic                        err_busy_q;
  logic [1:0]                  irq_mask;

  logic                        ctrl_wr;
  logic                        data_wr;
  logic                        busy_wr;
  logic                        err_clr;
  logic                        handshake;
  logic                        res_rd;
  logic [APB_BUS_SIZE-1:0]     ctrl_word;
  logic [APB_BUS_SIZE-1:0]     status_word;
  logic [APB_BUS_SIZE-1:0]     rd_mux;
  logic                        unused_wdata;

  assign unused_wdata = ^wdata;

  // Write/read strobes and busy-write detection
  always_comb begin
    ctrl_wr = wr_en && (wr_addr == A_CTRL);
    data_wr = 1'b0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (wr_en && (wr_addr == ADDR_WIDTH'(4 + k))) data_wr = 1'b1;
    end
    busy_wr   = (state_q == PUSH) && (ctrl_wr || data_wr);
    err_clr   = wr_en && (wr_addr == A_STATUS) && wdata[4];
    handshake = cmd_valid && cmd_ready;
    res_rd    = rd_en && (rd_addr == A_RESULT);
  end

  // Packed command: operands high, then id, then opcode
  always_comb begin
    csr_data = '0;
    csr_data[OPERATION_SIZE-1:0] = op_q;
    csr_data[OPERATION_SIZE +: ID_SIZE] = id_q;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      csr_data[HDR + k*DATA_SIZE +: DATA_SIZE] = data_q[k];
    end
  end

  // Push FSM with CTRL fields and command counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_valid   <= 1'b0;
      start_q     <= 1'b0;
      op_q        <= '0;
      id_q        <= '0;
      auto_id_q   <= 1'b0;
      cmd_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_wr) begin
            op_q      <= wdata[1 +: OPERATION_SIZE];
            id_q      <= wdata[8 +: ID_SIZE];
            auto_id_q <= wdata[16];
            if (wdata[0]) begin
              start_q   <= 1'b1;
              cmd_valid <= 1'b1;
              state_q   <= PUSH;
            end
          end
        end
        PUSH: begin
          if (handshake) begin
            start_q     <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_count_q <= cmd_count_q + CNT_WIDTH'(1);
            if (auto_id_q) id_q <= id_q + ID_SIZE'(1);
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  // Operand registers, frozen while a command is outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OPERANDS; k++) data_q[k] <= '0;
    end else if (state_q == IDLE) begin
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(4 + k)))
          data_q[k] <= wdata[DATA_SIZE-1:0];
      end
    end
  end

  // Result path: one-cycle pop, capture next edge, clear on read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_out_rd    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      res_count_q    <= '0;
    end else begin
      fifo_out_rd <= !result_valid_q && !fifo_out_empty && !fifo_out_rd;
      if (fifo_out_rd) begin
        result_q       <= fifo_out_data;
        result_valid_q <= 1'b1;
        res_count_q    <= res_count_q + CNT_WIDTH'(1);
      end else if (res_rd) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  // Sticky busy-write error; a new set beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n)        err_busy_q <= 1'b0;
    else if (busy_wr)  err_busy_q <= 1'b1;
    else if (err_clr)  err_busy_q <= 1'b0;
  end

`ifdef CSR_IRQ_EN
  // Interrupt mask and registered interrupt output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_mask <= 2'b00;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == A_IRQ)) irq_mask <= wdata[1:0];
      irq <= (result_valid_q & irq_mask[0]) | (err_busy_q & irq_mask[1]);
    end
  end
`else
  assign irq_mask = 2'b00;
  assign irq      = 1'b0;
`endif

  // Register read multiplexer
  always_comb begin
    ctrl_word = '0;
    ctrl_word[0] = start_q;
    ctrl_word[1 +: OPERATION_SIZE] = op_q;
    ctrl_word[8 +: ID_SIZE] = id_q;
    ctrl_word[16] = auto_id_q;
    status_word = '0;
    status_word[0] = fifo_out_empty;
    status_word[1] = fifo_in_full;
    status_word[2] = (state_q == PUSH);
    status_word[3] = result_valid_q;
    status_word[4] = err_busy_q;
    status_word[8 +: CNT_WIDTH] = cmd_count_q;
    status_word[16 +: CNT_WIDTH] = res_count_q;
    rd_mux = '0;
    case (rd_addr)
      A_CTRL:   rd_mux = ctrl_word;
      A_STATUS: rd_mux = status_word;
      A_RESULT: rd_mux = APB_BUS_SIZE'(result_q);
      A_IRQ:    rd_mux = APB_BUS_SIZE'(irq_mask);
      default:  rd_mux = '0;
    endcase
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (rd_addr == ADDR_WIDTH'(4 + k)) rd_mux = APB_BUS_SIZE'(data_q[k]);
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk) begin
    if (!rst_n)     rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_alu_csr_regfile.sv
// Directed bench for alu_csr_regfile.
// Checks push handshake, busy errors, auto id, result path and reset.
module tb_alu_csr_regfile;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [41:0] csr_data;
  logic        fifo_in_full;
  logic        fifo_out_empty;
  logic        fifo_out_rd;
  logic [24:0] fifo_out_data;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rv;
  logic [41:0] cmd1;

`ifdef CSR_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  alu_csr_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .csr_data(csr_data), .fifo_in_full(fifo_in_full),
    .fifo_out_empty(fifo_out_empty), .fifo_out_rd(fifo_out_rd),
    .fifo_out_data(fifo_out_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wdata = '0;
    rd_en = 1'b0; rd_addr = '0; cmd_ready = 1'b1;
    fifo_in_full = 1'b0; fifo_out_empty = 1'b1; fifo_out_data = '0;
    cmd1 = {16'hABCD, 16'h1234, 8'h05, 2'b01};
    tick(); tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_fifo_rd", fifo_out_rd, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    rd(4'd1, rv); chk("rst_status", rv, 32'h1);
    rd(4'd15, rv); chk("unmapped_rd", rv, 0);

    // basic push with ready high
    wr(4'd4, 32'h1234);
    wr(4'd5, 32'hABCD);
    wr(4'd0, 32'h0000_0503);
    chk("push_valid", cmd_valid, 1);
    chk("push_data", csr_data, cmd1);
    tick();
    chk("push_done", cmd_valid, 0);
    rd(4'd1, rv); chk("status_cnt1", rv, 32'h101);
    rd(4'd0, rv); chk("ctrl_start0", rv, 32'h502);

    // stall with ready low, write during PUSH
    cmd_ready = 1'b0;
    wr(4'd0, 32'h0000_0503);
    chk("stall_valid", cmd_valid, 1);
    wr(4'd4, 32'hFFFF);
    chk("stall_data", csr_data, cmd1);
    rd(4'd1, rv); chk("status_err", rv, 32'h115);
    tick(); tick();
    chk("stall_hold", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick();
    chk("stall_done", cmd_valid, 0);
    wr(4'd1, 32'h10);
    rd(4'd1, rv); chk("err_clear", rv, 32'h201);
    rd(4'd4, rv); chk("data0_kept", rv, 32'h1234);

    // auto id wrap
    wr(4'd0, 32'h0001_FF03);
    chk("auto_id_ff", csr_data[9:2], 8'hFF);
    tick();
    chk("auto_id_00", csr_data[9:2], 8'h00);
    wr(4'd0, 32'h0001_0003);
    chk("auto_id_00b", csr_data[9:2], 8'h00);
    tick();
    chk("auto_id_01", csr_data[9:2], 8'h01);
    rd(4'd0, rv); chk("ctrl_auto", rv, 32'h0001_0102);

    // result path
    wr(4'd3, 32'h1);
    rd(4'd3, rv); chk("irq_mask_rd", rv, {31'b0, IRQ_ON});
    fifo_out_data = 25'h1_5A5A;
    fifo_out_empty = 1'b0;
    tick();
    chk("pop_pulse", fifo_out_rd, 1);
    tick();
    chk("pop_end", fifo_out_rd, 0);
    chk("irq_pre", irq, 0);
    tick();
    chk("pop_single", fifo_out_rd, 0);
    chk("irq_rise", irq, IRQ_ON);
    rd(4'd1, rv); chk("status_rv", rv, 32'h0001_0408);
    rd(4'd2, rv); chk("result1", rv, 32'h0001_5A5A);
    chk("no_pop_on_read", fifo_out_rd, 0);
    chk("irq_hold", irq, IRQ_ON);
    fifo_out_data = 25'h0_BEEF;
    tick();
    chk("next_pop", fifo_out_rd, 1);
    chk("irq_fall", irq, 0);
    fifo_out_empty = 1'b1;
    tick();
    rd(4'd1, rv); chk("status_res2", rv, 32'h0002_0409);
    rd(4'd2, rv); chk("result2", rv, 32'h0000_BEEF);
    rd(4'd2, rv); chk("result_last", rv, 32'h0000_BEEF);

    // reset during PUSH and pending pop
    cmd_ready = 1'b0;
    wr(4'd0, 32'h0000_0503);
    fifo_out_data = 25'h1_FFFF;
    fifo_out_empty = 1'b0;
    tick();
    chk("pre_rst_valid", cmd_valid, 1);
    chk("pre_rst_pop", fifo_out_rd, 1);
    rst_n = 1'b0;
    fifo_out_empty = 1'b1;
    tick();
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_pop", fifo_out_rd, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_csr", csr_data, 0);
    rst_n = 1'b1;
    rd(4'd1, rv); chk("post_rst_status", rv, 32'h1);
    rd(4'd2, rv); chk("post_rst_result", rv, 0);
    rd(4'd4, rv); chk("post_rst_data0", rv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
